cpu_fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end with a prefetch queue; replaces the single-entry PC/instruction register path between the L1I port and decode.
- Issues sequential fetches on the core2il1/il12core val/ack port and buffers up to QDEPTH {pc, inst} entries.
- Redirects from the branch-resolve stage flush the queue and any in-flight fetch.

---
 rtl/cpu_fetch_pkg.sv | 21 ++
 rtl/cpu_fetch_queue_if.sv | 27 ++
 rtl/fq_ring.sv | 48 ++++
 rtl/cpu_fetch_queue.sv | 115 +++++++++++
 tb/tb_cpu_fetch_queue.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared constants for the instruction-fetch front end: entry layout, PC step,
// alignment mask and reset PC default.
package cpu_fetch_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_INST_W   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;
  localparam int unsigned ALIGN_MASK   = 3;

  // Queue entry layout: pc in the upper field, instruction in the lower field.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic int unsigned entry_w(input int unsigned aw, input int unsigned iw);
    return aw + iw;
  endfunction

endpackage

// File: rtl/cpu_fetch_queue_if.sv
// L1I request/response and decode-side handshake bundle for the fetch queue.
// master = fetch queue, slave = L1I/decode environment.
interface cpu_fetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
) ();

  logic              core2il1_val;
  logic [ADDR_W-1:0] core2il1_addr;
  logic              il12core_ack;
  logic [INST_W-1:0] il12core_rdata;
  logic              fq2dec_val;
  logic [INST_W-1:0] fq2dec_inst;
  logic [ADDR_W-1:0] fq2dec_pc;
  logic              dec2fq_rdy;

  modport master (
    output core2il1_val, core2il1_addr, fq2dec_val, fq2dec_inst, fq2dec_pc,
    input  il12core_ack, il12core_rdata, dec2fq_rdy
  );

  modport slave (
    input  core2il1_val, core2il1_addr, fq2dec_val, fq2dec_inst, fq2dec_pc,
    output il12core_ack, il12core_rdata, dec2fq_rdy
  );

endinterface

// File: rtl/fq_ring.sv
// Ring-buffer storage with head/tail/level tracking, push, pop and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fq_ring #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [LVL_W-1:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign level     = level_q;

endmodule

// File: rtl/cpu_fetch_queue.sv
// Instruction-fetch controller with prefetch queue: sequential issue, redirect/kill, flush.
// Define FQ_BYPASS_EN to forward an ack straight to decode when the queue is empty.
module cpu_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INST_W   = DEF_INST_W,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  cpu_fetch_queue_if.master           bus,
  input  logic                        redir_val,
  input  logic [ADDR_W-1:0]           redir_pc,
  output logic [$clog2(QDEPTH+1)-1:0] fq_level
);

  localparam int unsigned LVL_W   = $clog2(QDEPTH + 1);
  localparam int unsigned ENTRY_W = entry_w(ADDR_W, INST_W);

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic              kill_q, kill_d;

  logic              ack_fire, pending_after, can_issue;
  logic              push, pop, ring_empty;
  logic [ADDR_W-1:0] redir_tgt, pc_base;
  logic [LVL_W-1:0]  level;
  logic [ENTRY_W-1:0] head_entry;
  int                level_next;
`ifdef FQ_BYPASS_EN
  logic              bypass;
`endif

  always_comb begin
    ack_fire   = req_q & bus.il12core_ack;
    redir_tgt  = redir_pc & ~ADDR_W'(ALIGN_MASK);
    ring_empty = (level == '0);
`ifdef FQ_BYPASS_EN
    bypass = ring_empty & ack_fire & ~kill_q & ~redir_val;
    // A bypassed instruction taken by decode this cycle never lands in the ring.
    push   = ack_fire & ~kill_q & ~redir_val & ~(bypass & bus.dec2fq_rdy);
`else
    push   = ack_fire & ~kill_q & ~redir_val;
`endif
    pop        = ~ring_empty & bus.dec2fq_rdy & ~redir_val;
    level_next = redir_val ? 0 : int'(level) + int'(push) - int'(pop);

    pending_after = req_q & ~bus.il12core_ack;
    can_issue     = ~pending_after & (level_next < int'(QDEPTH));
    pc_base       = redir_val ? redir_tgt : next_pc_q;

    req_d     = req_q;
    addr_d    = addr_q;
    next_pc_d = pc_base;
    kill_d    = kill_q;

    if (can_issue) begin
      req_d     = 1'b1;
      addr_d    = pc_base;
      next_pc_d = pc_base + ADDR_W'(PC_INC);
    end else if (!pending_after) begin
      req_d = 1'b0;
    end

    // A redirect cannot cancel a request already on the bus; its data is dropped on ack.
    if (redir_val && pending_after) kill_d = 1'b1;
    else if (ack_fire)              kill_d = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      next_pc_q <= RESET_PC;
      kill_q    <= 1'b0;
    end else begin
      req_q     <= req_d;
      addr_q    <= addr_d;
      next_pc_q <= next_pc_d;
      kill_q    <= kill_d;
    end
  end

  fq_ring #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_ring (
    .clk       (sys_clk),
    .rst_n     (sys_rst),
    .flush     (redir_val),
    .push      (push),
    .push_data ({addr_q, bus.il12core_rdata}),
    .pop       (pop),
    .head_data (head_entry),
    .level     (level)
  );

  assign bus.core2il1_val  = req_q;
  assign bus.core2il1_addr = addr_q;
  assign fq_level          = level;

`ifdef FQ_BYPASS_EN
  assign bus.fq2dec_val  = ~ring_empty | bypass;
  assign bus.fq2dec_inst = bypass ? bus.il12core_rdata : head_entry[INST_W-1:0];
  assign bus.fq2dec_pc   = bypass ? addr_q : head_entry[ENTRY_W-1:INST_W];
`else
  assign bus.fq2dec_val  = ~ring_empty;
  assign bus.fq2dec_inst = head_entry[INST_W-1:0];
  assign bus.fq2dec_pc   = head_entry[ENTRY_W-1:INST_W];
`endif

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed bench for cpu_fetch_queue: sequential fetch, full queue, redirect/kill,
// double redirect, PC wrap and the empty-queue ack path (bypass when FQ_BYPASS_EN).
module tb_cpu_fetch_queue;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        redir_val;
  logic [31:0] redir_pc;
  logic [2:0]  fq_level;

  int total = 0;
  int bad   = 0;

  cpu_fetch_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

  cpu_fetch_queue #(
    .ADDR_W   (32),
    .INST_W   (32),
    .QDEPTH   (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .bus       (bus),
    .redir_val (redir_val),
    .redir_pc  (redir_pc),
    .fq_level  (fq_level)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs return to idle so checks see registered state only.
  task automatic step();
    @(posedge sys_clk);
    #1;
    bus.il12core_ack = 1'b0;
    redir_val        = 1'b0;
    #1;
  endtask

  task automatic drive(input logic ack, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic [31:0] rdata);
    bus.il12core_ack   = ack;
    bus.dec2fq_rdy     = rdy;
    redir_val          = rv;
    redir_pc           = rpc;
    bus.il12core_rdata = rdata;
  endtask

  // Check registered state, apply this cycle's inputs, clock once.
  task automatic cyc(input string tag, input logic ev, input logic [31:0] ea,
                     input logic efqv, input logic [31:0] epc, input int elvl,
                     input logic ack, input logic rdy, input logic rv, input logic [31:0] rpc);
    chk({tag, ".val"}, 64'(bus.core2il1_val), 64'(ev));
    if (ev) chk({tag, ".addr"}, 64'(bus.core2il1_addr), 64'(ea));
    chk({tag, ".fqv"}, 64'(bus.fq2dec_val), 64'(efqv));
    if (efqv) begin
      chk({tag, ".pc"}, 64'(bus.fq2dec_pc), 64'(epc));
      chk({tag, ".inst"}, 64'(bus.fq2dec_inst), 64'(inst_of(epc)));
    end
    chk({tag, ".lvl"}, 64'(fq_level), 64'(elvl));
    drive(ack, rdy, rv, rpc, inst_of(ea));
    step();
  endtask

  task automatic do_reset(input string tag);
    sys_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk({tag, ".rst_val"}, 64'(bus.core2il1_val), 64'd0);
    chk({tag, ".rst_addr"}, 64'(bus.core2il1_addr), 64'd0);
    chk({tag, ".rst_fqv"}, 64'(bus.fq2dec_val), 64'd0);
    chk({tag, ".rst_lvl"}, 64'(fq_level), 64'd0);
    step();
    sys_rst = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    do_reset("t0");

    // Streaming with decode always ready: level never exceeds 1.
    cyc("t1c0", 1, 32'h0, 0, 32'h0, 0, 1, 0, 0, 0);
    cyc("t1c1", 1, 32'h4, 1, 32'h0, 1, 1, 1, 0, 0);
    cyc("t1c2", 1, 32'h8, 1, 32'h4, 1, 1, 1, 0, 0);
    cyc("t1c3", 1, 32'hC, 1, 32'h8, 1, 1, 1, 0, 0);

    // Reset with a request outstanding.
    do_reset("t2");
    cyc("t2c0", 1, 32'h0,  0, 32'h0, 0, 1, 0, 0, 0);
    cyc("t2c1", 1, 32'h4,  1, 32'h0, 1, 1, 0, 0, 0);
    cyc("t2c2", 1, 32'h8,  1, 32'h0, 2, 1, 0, 0, 0);
    cyc("t2c3", 1, 32'hC,  1, 32'h0, 3, 1, 0, 0, 0);
    cyc("t2c4", 0, 32'hC,  1, 32'h0, 4, 0, 0, 0, 0);
    cyc("t2c5", 0, 32'hC,  1, 32'h0, 4, 0, 1, 0, 0);
    cyc("t2c6", 1, 32'h10, 1, 32'h4, 3, 1, 1, 0, 0);
    cyc("t2c7", 1, 32'h14, 1, 32'h8, 3, 0, 0, 0, 0);
    cyc("t2c8", 1, 32'h14, 1, 32'h8, 3, 0, 0, 0, 0);

    // Redirect while 0x8 is pending with a delayed ack.
    do_reset("t3");
    cyc("t3c0", 1, 32'h0,   0, 32'h0,   0, 1, 0, 0, 0);
    cyc("t3c1", 1, 32'h4,   1, 32'h0,   1, 1, 1, 0, 0);
    cyc("t3c2", 1, 32'h8,   1, 32'h4,   1, 0, 1, 1, 32'h103);
    cyc("t3c3", 1, 32'h8,   0, 32'h0,   0, 0, 1, 0, 0);
    cyc("t3c4", 1, 32'h8,   0, 32'h0,   0, 0, 1, 0, 0);
    cyc("t3c5", 1, 32'h8,   0, 32'h0,   0, 1, 1, 0, 0);
    cyc("t3c6", 1, 32'h100, 0, 32'h0,   0, 1, 0, 0, 0);
    cyc("t3c7", 1, 32'h104, 1, 32'h100, 1, 0, 0, 0, 0);

    // Redirect coinciding with ack and pop at level 2.
    do_reset("t4");
    cyc("t4c0", 1, 32'h0,  0, 32'h0, 0, 1, 0, 0, 0);
    cyc("t4c1", 1, 32'h4,  1, 32'h0, 1, 1, 0, 0, 0);
    cyc("t4c2", 1, 32'h8,  1, 32'h0, 2, 1, 1, 1, 32'h40);
    cyc("t4c3", 1, 32'h40, 0, 32'h0, 0, 0, 1, 0, 0);
    cyc("t4c4", 1, 32'h40, 0, 32'h0, 0, 0, 1, 0, 0);

    // Two redirects during one pending request, then redirect to the top of memory.
    do_reset("t5");
    cyc("t5c0", 1, 32'h0,         0, 32'h0,         0, 0, 1, 1, 32'h200);
    cyc("t5c1", 1, 32'h0,         0, 32'h0,         0, 0, 1, 1, 32'h300);
    cyc("t5c2", 1, 32'h0,         0, 32'h0,         0, 0, 1, 0, 0);
    cyc("t5c3", 1, 32'h0,         0, 32'h0,         0, 1, 1, 0, 0);
    cyc("t5c4", 1, 32'h300,       0, 32'h0,         0, 1, 0, 0, 0);
    cyc("t5c5", 1, 32'h304,       1, 32'h300,       1, 1, 1, 1, 32'hFFFF_FFFE);
    cyc("t5c6", 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 1, 0, 0, 0);
    cyc("t5c7", 1, 32'h0,         1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0);

    // Ack into an empty queue with decode ready.
    do_reset("t6");
    chk("t6.val", 64'(bus.core2il1_val), 64'd1);
    chk("t6.addr", 64'(bus.core2il1_addr), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    #1;
`ifdef FQ_BYPASS_EN
    chk("t6.byp_fqv", 64'(bus.fq2dec_val), 64'd1);
    chk("t6.byp_inst", 64'(bus.fq2dec_inst), 64'hDEAD_BEEF);
    chk("t6.byp_pc", 64'(bus.fq2dec_pc), 64'd0);
    step();
    chk("t6.byp_lvl", 64'(fq_level), 64'd0);
    chk("t6.byp_fqv1", 64'(bus.fq2dec_val), 64'd0);
`else
    chk("t6.fqv", 64'(bus.fq2dec_val), 64'd0);
    step();
    chk("t6.lvl", 64'(fq_level), 64'd1);
    chk("t6.fqv1", 64'(bus.fq2dec_val), 64'd1);
    chk("t6.inst", 64'(bus.fq2dec_inst), 64'hDEAD_BEEF);
`endif
    chk("t6.addr1", 64'(bus.core2il1_addr), 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
